// File: rtl/dec_unbinder_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dec_unbinder_seq (with shared package hdc_pkg)
// Brief    : Decode-path unbinding stage. Accepts one bound hypervector per
//            cycle over valid/ready, rotates it right by the feature's entry
//            in the shared SHIFTS table and emits the recovered level HV
//            together with its feature index. One frame = NUM_FEATURES HVs.
// Revision : 1.0 - initial release
// ============================================================================

package hdc_pkg;
  localparam int HV_DIM     = 1024;
  localparam int NUM_SHIFTS = 32;
  // Per-feature circular shift amounts shared with the encoder binders.
  // Entries at or above HV_DIM are legal and are reduced modulo HV_DIM.
  localparam int SHIFTS [NUM_SHIFTS] = '{
    3,   0,   1,   7,   64,  1023, 1030, 512,
    5,   2,   100, 999, 11,  256,  1024, 13,
    17,  33,  65,  129, 257, 513,  31,   63,
    127, 255, 511, 9,   19,  37,   73,   145
  };
endpackage

module dec_unbinder_seq #(
  parameter int HV_DIM       = hdc_pkg::HV_DIM,
  parameter int NUM_FEATURES = 16,
  parameter int SHIFT_BASE   = 0,
  parameter int FIDX_W       = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_decoding,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] bound_hv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] level_hv,
  output logic [FIDX_W-1:0] feature_idx,
  output logic              frame_done
);

  localparam int SHIFT_W  = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
  localparam int TBL_SIZE = 2 ** FIDX_W;
  localparam logic [FIDX_W-1:0] LAST_IDX = FIDX_W'(NUM_FEATURES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [FIDX_W-1:0]     r_cnt;
  logic [SHIFT_W-1:0]    w_shift_tbl [TBL_SIZE];
  logic [SHIFT_W-1:0]    w_shift;
  logic [HV_DIM-1:0]     w_rot;
  logic                  w_accept;
  logic                  w_consume;

  // Shift table slice for this instance, reduced modulo HV_DIM at elaboration
  // time. Table slots beyond NUM_FEATURES are never addressed by r_cnt.
  for (genvar g = 0; g < TBL_SIZE; g++) begin : g_shift_tbl
    if (g < NUM_FEATURES) begin : g_used
      assign w_shift_tbl[g] = SHIFT_W'(hdc_pkg::SHIFTS[SHIFT_BASE + g] % HV_DIM);
    end else begin : g_unused
      assign w_shift_tbl[g] = '0;
    end
  end

  assign w_shift = w_shift_tbl[r_cnt];

  // Right rotation: level[j] = bound[(j+S) mod HV_DIM]. Shifting a doubled
  // copy right by S and keeping the low half yields exactly that wrap.
  assign w_rot = HV_DIM'({bound_hv, bound_hv} >> w_shift);

  // Input is open only while running and the output slot is free or draining.
  assign in_ready  = (r_state == ST_RUN) && (!out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid && out_ready;

  // Frame FSM with registered output slot, feature counter and done pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      out_valid   <= 1'b0;
      level_hv    <= '0;
      feature_idx <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_decoding) begin
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            // Reload in the same edge as a consume, so no bubble appears.
            level_hv    <= w_rot;
            feature_idx <= r_cnt;
            out_valid   <= 1'b1;
            if (r_cnt == LAST_IDX) begin
              r_state <= ST_DRAIN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (w_consume) begin
            out_valid <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_consume) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/dec_unbinder_seq.md
# dec_unbinder_seq

Sequential unbinding stage for the decode path. It undoes the per-feature circular-shift binding that the encoder binders apply, recovering each feature's level hypervector from its bound form. It accepts one bound HV per cycle over a valid/ready handshake and rotates it back by that feature's entry in the shared `SHIFTS` table. It tracks the feature index across a frame of `NUM_FEATURES` vectors and emits the recovered level HVs to the downstream item-memory matcher.

## Interface
- `HV_DIM`, default 1024: hypervector width in bits (shared package value).
- `NUM_FEATURES`, default 16: bound vectors per frame; must be ≥1.
- `SHIFT_BASE`, default 0: offset into package `SHIFTS`; feature k uses `SHIFTS[SHIFT_BASE+k]`.
- `FIDX_W`, default `$clog2(NUM_FEATURES)` (minimum 1): feature-index width.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `nrst`, input, 1: asynchronous, active-low reset.
- `start_decoding`, input, 1: frame start pulse; sampled only in IDLE.
- `in_valid`, input, 1: `bound_hv` is valid.
- `in_ready`, output, 1: block can accept `bound_hv` this cycle.
- `bound_hv`, input, HV_DIM: bound (shifted) hypervector.
- `out_valid`, output, 1: `level_hv` and `feature_idx` are valid.
- `out_ready`, input, 1: downstream accepts the output.
- `level_hv`, output, HV_DIM: recovered (unbound) hypervector.
- `feature_idx`, output, FIDX_W: feature number of `level_hv`.
- `frame_done`, output, 1: one-cycle pulse after the last feature of a frame is consumed.

## Operation
- Binding convention: the encoder rotates left by `SHIFT`, so bit i moves to bit (i+SHIFT) mod HV_DIM. This block rotates right by the same amount: `level_hv[j] = bound_hv[(j+S) mod HV_DIM]`, with S = `SHIFTS[SHIFT_BASE+cnt]` mod HV_DIM. S=0 passes the vector through unchanged.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: `in_ready`=0. When `start_decoding`=1, clear `cnt` and go to RUN.
  - RUN: `in_ready = !out_valid || out_ready`. An accept occurs when `in_valid && in_ready`. On accept:
    - `level_hv` ← rotated `bound_hv`;
    - `feature_idx` ← `cnt`;
    - `out_valid` ← 1;
    - `cnt` ← `cnt`+1.
    - If the accepted feature was `cnt == NUM_FEATURES-1`, go to DRAIN instead of incrementing further.
  - DRAIN: `in_ready`=0. When `out_valid && out_ready`, set `out_valid` ← 0, pulse `frame_done` for one cycle, and go to IDLE.
- Output register holds: while `out_valid && !out_ready`, `level_hv` and `feature_idx` must not change.
- `out_valid` falls on consumption unless a new accept happens in the same cycle.
- `start_decoding` is ignored in RUN and DRAIN; no frame restart mid-frame.
- `cnt` never exceeds `NUM_FEATURES-1`; there is no wrap inside a frame. Each frame restarts at 0.

## Timing
- Reset (async assert, synchronous release): state=IDLE, `cnt`=0, `in_ready`=0, `out_valid`=0, `level_hv`=0, `feature_idx`=0, `frame_done`=0.
- Reset asserted mid-frame aborts the frame. Any in-flight output is dropped and `frame_done` is not produced.
- Latency: accept at edge N → `out_valid`=1 with data after edge N; one cycle.
- Throughput: 1 vector/cycle with `out_ready` held high.
- Simultaneous consume and accept in RUN: the output register reloads in the same edge, so `out_valid` stays 1 with no bubble.
- `in_ready` is combinational from the state, `out_valid`, and `out_ready`. There is no combinational path from `in_valid` to `out_valid`.
- `frame_done` is asserted the cycle after the last handshake on the output. With `out_ready`=1 throughout, that is 2 cycles after the last input accept.
- Frame-to-frame: the earliest next `start_decoding` is sampled in the cycle `frame_done` is high (state is IDLE).

## Test plan
- Rotation, no wrap: HV_DIM=1024, S=3, `bound_hv` with only bit 5 set → `level_hv` with only bit 2 set, `feature_idx`=0, one cycle after accept.
- Wrap-around: S=3, only bit 1 set → only bit 1022 set. S=0, pattern 0xA5 in the low byte → identical output.
- Full frame at full rate: NUM_FEATURES=16, `in_valid` and `out_ready` held at 1 → 16 outputs on consecutive cycles with `feature_idx` 0..15, each using `SHIFTS[SHIFT_BASE+k]`. `frame_done` is a single pulse 2 cycles after the 16th accept, then `in_ready`=0.
- Backpressure: `out_ready`=0 for 5 cycles at feature 7 → `level_hv` and `feature_idx`=7 stable, `in_ready`=0 throughout. Release → feature 8 accepted in the same cycle as the consume.
- Protocol guards: `start_decoding` during RUN → no counter reset. `in_valid` in IDLE → no accept and `out_valid` stays 0.
- Reset mid-frame: `nrst` low at feature 9 → all outputs 0 immediately (asynchronously). After release, a new frame starts at `feature_idx`=0 and there is no `frame_done` from the aborted frame.
